serial_neg_deser: RTL and testbench
===================================

Name: serial_neg_deser

Overview:
- Receive end of the serial two's-complement link: accepts an LSB-first bit stream, one bit per accepted cycle.
- Optionally negates the stream on the fly (serial two's complement: pass bits up to and including the first 1, invert all later bits).
- Reassembles each WIDTH-bit frame into a parallel word and presents it on a valid/ready output port.
- Sits between the serial complementer output and the parallel datapath.

Parameters:
- WIDTH, 8, bits per frame and width of out_data (minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clear  input  1  synchronous abort; discards any partial frame and any held word.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data, LSB first.
- in_ready  output  1  block can accept a bit this cycle.
- sel  input  1  1 = negate the frame, 0 = pass through. Sampled on the first accepted bit of each frame.
- out_valid  output  1  out_data holds a complete frame.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  reassembled (possibly negated) word.
- out_ovf  output  1  negation overflow: sel=1 and input word = 1 followed by WIDTH-1 zeros.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, bit count=0, seen_one=0, latched sel=0, shift register=0, out_valid=0, out_data=0, out_ovf=0. Reset mid-frame drops the partial frame; the next accepted bit starts a new frame.
- States:
  - IDLE: no bits held; in_ready=1.
  - SHIFT: 1..WIDTH-1 bits held; in_ready=1.
  - HOLD: word presented; in_ready=0.
- Transfer rules:
  - A bit transfer occurs when in_valid & in_ready.
  - Gaps in in_valid are allowed in any state; state and count do not change while idle-waiting.
- First bit of a frame (IDLE, transfer):
  - Latch sel.
  - Process the bit with seen_one=0.
  - count=1; go to SHIFT. If WIDTH=1 this path is disallowed (minimum WIDTH is 2).
- Per-bit transform (for each transferred bit b):
  - Output bit o = b if latched sel=0 or seen_one=0; otherwise o = ~b.
  - seen_one is set when b=1 (raw input bit).
  - Shift right: o enters at MSB. After WIDTH bits, the first bit received sits in bit 0.
- Frame completion: on the WIDTH-th transfer, the shift register including that bit is copied to out_data; out_valid=1 and state=HOLD on the next cycle.
  - Latency: out_valid rises 1 cycle after the last bit transfer.
- out_ovf is set with out_valid when latched sel=1 and the first raw 1 was the WIDTH-th bit (i.e., out_data = 1 followed by WIDTH-1 zeros). Otherwise 0.
  - Zero input with sel=1 gives out_data=0, out_ovf=0.
- HOLD:
  - out_data and out_ovf are held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid=0, count=0, seen_one=0, state=IDLE on the next cycle.
  - in_ready=0 throughout HOLD, so no bit can be lost. Back-to-back frames therefore cost one bubble cycle.
- clear=1 (synchronous):
  - From any state: next cycle state=IDLE, count=0, seen_one=0, out_valid=0, out_ovf=0. out_data value is don't-care.
  - A bit presented in the same cycle as clear is dropped.
- Priority: rst > clear > out handshake > bit transfer.
- out_data does not change while out_valid=0 except at frame completion.

Decomposition:
- Package serial_neg_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, SHIFT, HOLD};
  - function clog2-based count width CNT_W(WIDTH).
- One sub-module, serial_neg_bit: the sel/seen_one bit transform (clk, rst, clear, start, en, sel, b -> o, seen_one).
  - Reusable by the serial complementer transmitter.
  - Kept registered-state only; the shift/handshake FSM stays in the top module.

Test Plan:
- WIDTH=8, sel=1, bits of 0x05 LSB-first (1,0,1,0,0,0,0,0), continuous in_valid, out_ready=1 -> out_valid one cycle after the 8th bit, out_data=0xFB, out_ovf=0.
- sel=0, 0xA5 streamed with in_valid gaps of 2 cycles between bits -> out_data=0xA5, out_ovf=0. Toggling sel after the first bit does not affect the result.
- sel=1, 0x80 -> out_data=0x80, out_ovf=1. sel=1, 0x00 -> out_data=0x00, out_ovf=0.
- Backpressure: frame 0x3C with sel=1, out_ready=0 for 5 cycles:
  - out_data=0xC4 held stable; in_ready=0 throughout.
  - in_valid held high meanwhile transfers no bits.
  - After out_ready, the next frame 0x01 with sel=1 yields 0xFF.
- clear asserted after 3 bits of a frame, then full frame 0x7F with sel=1 -> out_data=0x81. No stale bits. Clear during HOLD drops out_valid next cycle.
- rst asserted asynchronously mid-frame (between clock edges, after 5 bits) -> all outputs 0 immediately. A following full frame 0x02 with sel=0 -> out_data=0x02.

Source files
------------

// File: rtl/serial_neg_pkg.sv
// Shared types and sizing helpers for the serial negate / deserialize blocks.
package serial_neg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    // Width of a bit counter that must hold 0..width-1 (never narrower than 1 bit).
    function automatic int CNT_W(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_neg_bit.sv
// Serial two's-complement bit transform: passes bits up to and including the
// first raw 1, then inverts every later bit when negation is selected.
module serial_neg_bit (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic start,
    input  logic en,
    input  logic sel,
    input  logic b,
    output logic o,
    output logic seen_one,
    output logic sel_latched
);

    logic sel_q;
    logic seen_q;
    logic invert;

    // The first bit of a frame always passes unchanged, so start masks the held state.
    always_comb begin
        invert = ~start & sel_q & seen_q;
        o      = b ^ invert;
    end

    // Latch sel on the first bit and remember whether a raw 1 has gone by.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q  <= 1'b0;
            seen_q <= 1'b0;
        end else if (clear) begin
            seen_q <= 1'b0;
        end else if (en) begin
            if (start) begin
                sel_q  <= sel;
                seen_q <= b;
            end else begin
                seen_q <= seen_q | b;
            end
        end
    end

    assign seen_one    = seen_q;
    assign sel_latched = sel_q;

endmodule

// File: rtl/serial_neg_deser.sv
// Receive side of the serial two's-complement link: optionally negates an
// LSB-first bit stream and reassembles it into WIDTH-bit words on a
// valid/ready port.
module serial_neg_deser
    import serial_neg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int            CW   = CNT_W(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] next_shreg;
    logic             xfer;
    logic             handshake;
    logic             bit_o;
    logic             seen_one;
    logic             sel_latched;
    logic             bit_clear;
    logic             ovf_now;
    logic             last_bit;

    // Handshake qualifiers; a bit offered alongside clear is dropped.
    always_comb begin
        in_ready   = (state != HOLD);
        out_valid  = (state == HOLD);
        xfer       = in_valid & in_ready & ~clear;
        handshake  = out_valid & out_ready & ~clear;
        last_bit   = (count == LAST);
        next_shreg = {bit_o, shreg[WIDTH-1:1]};
        bit_clear  = clear | handshake;
        ovf_now    = sel_latched & ~seen_one & in_bit;
    end

    serial_neg_bit u_bit (
        .clk         (clk),
        .rst         (rst),
        .clear       (bit_clear),
        .start       (state == IDLE),
        .en          (xfer),
        .sel         (sel),
        .b           (in_bit),
        .o           (bit_o),
        .seen_one    (seen_one),
        .sel_latched (sel_latched)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: clear wins, then the output handshake, then bit transfers.
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (xfer) next_state = SHIFT;
                SHIFT:   if (xfer && last_bit) next_state = HOLD;
                HOLD:    if (out_ready) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Bit counter, shift register and the presented word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            shreg    <= '0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            out_ovf <= 1'b0;
        end else if (handshake) begin
            count   <= '0;
            out_ovf <= 1'b0;
        end else if (xfer) begin
            shreg <= next_shreg;
            if (last_bit) begin
                count    <= '0;
                out_data <= next_shreg;
                out_ovf  <= ovf_now;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_neg_deser.sv
// Self-checking bench for serial_neg_deser: hand-derived vector table,
// directed corner sequences and randomized frames against a word-level model.
module tb_serial_neg_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         in_valid;
    logic         in_bit;
    logic         in_ready;
    logic         sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] word;
        bit         sel;
        int         gap;
        logic [7:0] exp_data;
        bit         exp_ovf;
    } vec_t;

    vec_t vecs[8];

    serial_neg_deser #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // Word-level reference: negation is arithmetic two's complement.
    function automatic logic [7:0] model_data(input logic [7:0] w, input bit s);
        logic [7:0] r;
        r = s ? 8'(~w + 8'd1) : w;
        return r;
    endfunction

    function automatic bit model_ovf(input logic [7:0] w, input bit s);
        return s && (w == 8'h80);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input bit b, input bit s);
        int budget;
        bit accepted;
        budget   = 0;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_bit   = b;
        sel      = s;
        while (!accepted && budget < 100) begin
            accepted = in_ready;
            tick();
            budget++;
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("bit_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] word, input bit s_first, input bit s_rest,
                                 input int gap, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    in_bit   = 1'($urandom);
                    sel      = 1'($urandom);
                    tick();
                end
            end
            if (i == W - 1) checkOutput("valid_before_last", 32'(out_valid), 32'd0);
            sendBit(word[i], (i == 0) ? s_first : s_rest);
        end
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] exp_d, input bit exp_o, input int delay);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'(out_data), 32'(exp_d));
        checkOutput({tag, "_ovf"}, 32'(out_ovf), 32'(exp_o));
        out_ready = 1'b0;
        for (int d = 0; d < delay; d++) begin
            tick();
            checkOutput({tag, "_hold_data"}, 32'(out_data), 32'(exp_d));
            checkOutput({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "_release"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        sel       = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{8'h05, 1'b1, 0, 8'hFB, 1'b0};
        vecs[1] = '{8'hA5, 1'b0, 2, 8'hA5, 1'b0};
        vecs[2] = '{8'h80, 1'b1, 0, 8'h80, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 1'b0};
        vecs[4] = '{8'h7F, 1'b1, 0, 8'h81, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 0, 8'hFF, 1'b0};
        vecs[6] = '{8'h02, 1'b0, 1, 8'h02, 1'b0};
        vecs[7] = '{8'h80, 1'b0, 0, 8'h80, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_data", 32'(out_data), 32'd0);
        checkOutput("reset_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("idle_ready", 32'(in_ready), 32'd1);

        $display("[TB] vector table");
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].word, vecs[v].sel, vecs[v].sel, vecs[v].gap, W);
            checkFrame($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_ovf, 1);
        end

        $display("[TB] sel toggled after first bit");
        applyStimulus(8'hA5, 1'b0, 1'b1, 2, W);
        checkFrame("sel_toggle", 8'hA5, 1'b0, 0);

        $display("[TB] backpressure");
        applyStimulus(8'h3C, 1'b1, 1'b1, 0, W);
        checkOutput("bp_data0", 32'(out_data), 32'hC4);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_data", 32'(out_data), 32'hC4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_release", 32'(out_valid), 32'd0);
        applyStimulus(8'h01, 1'b1, 1'b1, 0, W);
        checkFrame("bp_next", 8'hFF, 1'b0, 0);

        $display("[TB] clear mid-frame");
        applyStimulus(8'hFF, 1'b1, 1'b1, 0, 3);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        checkOutput("clear_mid_valid", 32'(out_valid), 32'd0);
        checkOutput("clear_mid_ready", 32'(in_ready), 32'd1);
        applyStimulus(8'h7F, 1'b1, 1'b1, 0, W);
        checkFrame("clear_mid_frame", 8'h81, 1'b0, 0);

        $display("[TB] clear during hold");
        applyStimulus(8'h80, 1'b1, 1'b1, 0, W);
        checkOutput("clear_hold_ovf_before", 32'(out_ovf), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clear_hold_valid", 32'(out_valid), 32'd0);
        checkOutput("clear_hold_ovf", 32'(out_ovf), 32'd0);
        checkOutput("clear_hold_ready", 32'(in_ready), 32'd1);

        $display("[TB] async reset mid-frame");
        applyStimulus(8'hA5, 1'b0, 1'b0, 0, W);
        checkFrame("pre_reset", 8'hA5, 1'b0, 0);
        applyStimulus(8'hFF, 1'b1, 1'b1, 0, 5);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("areset_valid", 32'(out_valid), 32'd0);
        checkOutput("areset_data", 32'(out_data), 32'd0);
        checkOutput("areset_ovf", 32'(out_ovf), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(8'h02, 1'b0, 1'b0, 0, W);
        checkFrame("post_reset", 8'h02, 1'b0, 0);

        $display("[TB] randomized frames");
        for (int n = 0; n < 40; n++) begin
            logic [7:0] w;
            bit s;
            w = 8'($urandom_range(0, 255));
            if (n % 10 == 0) w = 8'h80;
            s = 1'($urandom);
            applyStimulus(w, s, 1'($urandom), $urandom_range(0, 2), W);
            checkFrame($sformatf("rand%0d", n), model_data(w, s), model_ovf(w, s), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
